// File: rtl/usbf_wb_arbiter.sv
// Two-master to one-slave Wishbone arbiter for the usbf core port.
// Ownership is held per CYC, ties alternate round-robin, and a watchdog aborts hung accesses.
module usbf_wb_arbiter #(
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 32,
  parameter int TMO_CYC = 255
) (
  input  logic              clk_i,
  input  logic              nrst_i,
  input  logic [ADDR_W-1:0] m0_adr_i,
  input  logic [DATA_W-1:0] m0_dat_i,
  output logic [DATA_W-1:0] m0_dat_o,
  input  logic              m0_we_i,
  input  logic              m0_stb_i,
  input  logic              m0_cyc_i,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  input  logic [ADDR_W-1:0] m1_adr_i,
  input  logic [DATA_W-1:0] m1_dat_i,
  output logic [DATA_W-1:0] m1_dat_o,
  input  logic              m1_we_i,
  input  logic              m1_stb_i,
  input  logic              m1_cyc_i,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic [ADDR_W-1:0] s_adr_o,
  output logic [DATA_W-1:0] s_dat_o,
  input  logic [DATA_W-1:0] s_dat_i,
  output logic              s_we_o,
  output logic              s_stb_o,
  output logic              s_cyc_o,
  input  logic              s_ack_i,
  output logic [1:0]        grant_o,
  output logic              timeout_o
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, ERR} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);

  state_t              state_q;
  logic [1:0]          grant_q;
  logic                last_m1_q;
  logic [15:0]         cnt_q;
  logic                err0_q, err1_q;
  logic                timeout_q;
  logic [ADDR_W-1:0]   adr_hold_q;
  logic [DATA_W-1:0]   dat_hold_q;

  logic own0, own1, stall, err_owner_cyc;

  assign own0 = (state_q == OWN0);
  assign own1 = (state_q == OWN1);

  // Address/data keep their last driven value whenever nobody owns the slave.
  always_comb begin
    s_adr_o = adr_hold_q;
    s_dat_o = dat_hold_q;
    s_we_o  = 1'b0;
    s_stb_o = 1'b0;
    s_cyc_o = 1'b0;
    if (own0) begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_we_o  = m0_we_i;
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_cyc_i & m0_stb_i;
    end else if (own1) begin
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_we_o  = m1_we_i;
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_cyc_i & m1_stb_i;
    end
  end

  assign stall         = s_stb_o & ~s_ack_i;
  assign err_owner_cyc = grant_q[0] ? m0_cyc_i : m1_cyc_i;

  assign m0_dat_o  = s_dat_i;
  assign m1_dat_o  = s_dat_i;
  assign m0_ack_o  = own0 & s_stb_o & s_ack_i;
  assign m1_ack_o  = own1 & s_stb_o & s_ack_i;
  assign m0_err_o  = err0_q;
  assign m1_err_o  = err1_q;
  assign grant_o   = grant_q;
  assign timeout_o = timeout_q;

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q    <= IDLE;
      grant_q    <= 2'b00;
      last_m1_q  <= 1'b1;
      cnt_q      <= '0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
      timeout_q  <= 1'b0;
      adr_hold_q <= '0;
      dat_hold_q <= '0;
    end else begin
      err0_q <= 1'b0;
      err1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (m0_cyc_i && (!m1_cyc_i || last_m1_q)) begin
            state_q <= OWN0;
            grant_q <= 2'b01;
          end else if (m1_cyc_i) begin
            state_q <= OWN1;
            grant_q <= 2'b10;
          end
        end
        OWN0, OWN1: begin
          adr_hold_q <= s_adr_o;
          dat_hold_q <= s_dat_o;
          if (!s_cyc_o) begin
            state_q   <= IDLE;
            grant_q   <= 2'b00;
            last_m1_q <= own1;
            cnt_q     <= '0;
          end else if (stall) begin
            if (cnt_q == TMO_LAST) begin
              state_q   <= ERR;
              err0_q    <= own0;
              err1_q    <= own1;
              timeout_q <= 1'b1;
              cnt_q     <= '0;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end else begin
            cnt_q <= '0;
          end
        end
        ERR: begin
          // The grant is kept so the stuck owner is identified until it releases CYC.
          if (!err_owner_cyc) begin
            state_q   <= IDLE;
            grant_q   <= 2'b00;
            last_m1_q <= grant_q[1];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usbf_wb_arbiter.sv
// Directed bench for usbf_wb_arbiter: single access, tie alternation, burst hold,
// watchdog timeout, asynchronous reset mid-access and stray acknowledge.
module tb_usbf_wb_arbiter;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              nrst = 1'b1;
  logic [ADDR_W-1:0] m0_adr = '0, m1_adr = '0;
  logic [DATA_W-1:0] m0_dat = '0, m1_dat = '0;
  logic [DATA_W-1:0] m0_rdat, m1_rdat;
  logic              m0_we = 0, m0_stb = 0, m0_cyc = 0;
  logic              m1_we = 0, m1_stb = 0, m1_cyc = 0;
  logic              m0_ack, m0_err, m1_ack, m1_err;
  logic [ADDR_W-1:0] s_adr;
  logic [DATA_W-1:0] s_dat_o, s_dat_i = '0;
  logic              s_we, s_stb, s_cyc, s_ack = 0;
  logic [1:0]        grant;
  logic              timeout;

  int checks = 0;
  int errors = 0;

  usbf_wb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TMO_CYC(8)) dut (
    .clk_i(clk), .nrst_i(nrst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(m0_rdat), .m0_we_i(m0_we),
    .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(m1_rdat), .m1_we_i(m1_we),
    .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_we_o(s_we),
    .s_stb_o(s_stb), .s_cyc_o(s_cyc), .s_ack_i(s_ack),
    .grant_o(grant), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0;
    #2 nrst = 1'b1;
  endtask

  initial begin
    // Reset state
    #1 nrst = 1'b0;
    #1;
    check("rst_grant", grant, 0);
    check("rst_cyc", s_cyc, 0);
    check("rst_stb", s_stb, 0);
    check("rst_timeout", timeout, 0);
    check("rst_adr", s_adr, 0);
    check("rst_dat", s_dat_o, 0);
    tick(); nrst = 1'b1;

    // Single write from m0, acked on the third owned cycle
    tick(); m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 18'h8; m0_dat = 32'hFF;
    #1 check("t1_latency", s_cyc, 0);
    tick(); #1;
    check("t1_grant", grant, 2'b01);
    check("t1_cyc", s_cyc, 1);
    check("t1_adr", s_adr, 32'h8);
    check("t1_dat", s_dat_o, 32'hFF);
    check("t1_we", s_we, 1);
    tick();
    tick(); s_ack = 1;
    #1 check("t1_ack0", m0_ack, 1);
    check("t1_ack1", m1_ack, 0);
    tick(); s_ack = 0; m0_cyc = 0; m0_stb = 0; m0_we = 0;
    #1 check("t1_ack0_off", m0_ack, 0);
    tick(); m0_adr = 18'h3;
    #1 check("t1_grant_rel", grant, 2'b00);
    check("t1_adr_hold", s_adr, 32'h8);
    check("t1_dat_hold", s_dat_o, 32'hFF);
    check("t1_we_idle", s_we, 0);
    $display("txn single_write adr=0x8 dat=0xFF");

    // Tie after reset goes to m0, then alternates
    do_reset();
    tick(); m0_cyc = 1; m1_cyc = 1;
    tick(); #1 check("t2_first", grant, 2'b01);
    m0_cyc = 0;
    tick(); #1 check("t2_dead", grant, 2'b00);
    tick(); #1 check("t2_second", grant, 2'b10);
    m1_cyc = 0;
    tick(); #1 check("t2_idle", grant, 2'b00);
    m0_cyc = 1; m1_cyc = 1;
    tick(); #1 check("t2_third", grant, 2'b01);
    m0_cyc = 0; m1_cyc = 0;
    tick(); #1 check("t2_idle2", grant, 2'b00);
    $display("txn tie_alternation");

    // Burst hold: m1 wins the tie (m0 was last) and keeps the bus for 4 reads
    tick(); m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 18'h20; m0_cyc = 1;
    for (int k = 1; k <= 4; k++) begin
      tick(); s_ack = 1; s_dat_i = 32'h11 * k;
      #1 check("t3_grant", grant, 2'b10);
      check("t3_ack1", m1_ack, 1);
      check("t3_ack0", m0_ack, 0);
      check("t3_rdat", m1_rdat, 32'h11 * k);
      $display("txn burst_read %0d dat=0x%0h", k, m1_rdat);
    end
    tick(); s_ack = 0; m1_cyc = 0; m1_stb = 0;
    #1 check("t3_hold_last", grant, 2'b10);
    tick(); #1 check("t3_dead", grant, 2'b00);
    tick(); #1 check("t3_m0_next", grant, 2'b01);
    m0_cyc = 0;

    // Watchdog: 8 stalled cycles then a single err pulse
    tick(); m0_cyc = 1; m0_stb = 1; m0_adr = 18'h40;
    for (int i = 1; i <= 8; i++) begin
      tick(); #1;
      check("t4_no_err", m0_err, 0);
      check("t4_stb", s_stb, 1);
    end
    tick(); #1;
    check("t4_err", m0_err, 1);
    check("t4_err_other", m1_err, 0);
    check("t4_stb_drop", s_stb, 0);
    check("t4_cyc_drop", s_cyc, 0);
    check("t4_timeout", timeout, 1);
    m1_cyc = 1;
    tick(); #1;
    check("t4_err_pulse", m0_err, 0);
    check("t4_err_cyc", s_cyc, 0);
    s_ack = 1;
    #1 check("t4_err_noack", m0_ack, 0);
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    tick(); #1 check("t4_dead", grant, 2'b00);
    tick(); #1 check("t4_m1", grant, 2'b10);
    check("t4_sticky", timeout, 1);
    $display("txn timeout m0");

    // Asynchronous reset while m1 strobes
    m1_stb = 1;
    #1 check("t5_stb_on", s_stb, 1);
    #1 nrst = 1'b0;
    #1;
    check("t5_cyc", s_cyc, 0);
    check("t5_stb", s_stb, 0);
    check("t5_grant", grant, 2'b00);
    check("t5_timeout", timeout, 0);
    tick(); nrst = 1'b1; m1_stb = 0; m0_cyc = 1;
    tick(); #1 check("t5_tie_m0", grant, 2'b01);
    m0_cyc = 0; m1_cyc = 0;
    tick(); #1 check("t5_idle", grant, 2'b00);
    $display("txn reset_mid_access");

    // Stray ack in IDLE
    tick(); s_ack = 1;
    #1 check("t6_ack0", m0_ack, 0);
    check("t6_ack1", m1_ack, 0);
    tick(); s_ack = 0;
    #1 check("t6_grant", grant, 2'b00);
    check("t6_cyc", s_cyc, 0);
    $display("txn stray_ack");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
